// File: rtl/led_bank_arbiter_if.sv
// led_bank_arbiter_if
// Bundles the requester-side and LED-side signals of the LED bank arbiter.
// The requesters (master) drive req/pat/duty. The arbiter (slave) drives
// the grant, owner, LED bus and status outputs.
interface led_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int PWM_W = 4
);
  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] pat;
  logic [PWM_W-1:0]  duty;

  logic [NREQ-1:0]   gnt;
  logic [OW-1:0]     owner;
  logic [7:0]        leds;
  logic              busy;
  logic              slot_done;

  modport master (
    output req, pat, duty,
    input  gnt, owner, leds, busy, slot_done
  );

  modport slave (
    input  req, pat, duty,
    output gnt, owner, leds, busy, slot_done
  );
endinterface

// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter
// Time-multiplexes the shared 8-LED bank among NREQ pattern requesters.
// Grants are round-robin, each slot lasts DWELL cycles unless the owner
// drops its request. The pattern is latched at grant time and drives the
// LED pins from a register.
// Optional feature macro: LED_BANK_PWM_EN enables global PWM dimming of
// the LED bus through the duty input. Without it, duty is ignored.
module led_bank_arbiter #(
  parameter int NREQ    = 4,
  parameter int DWELL_W = 16,
  parameter int DWELL   = 1000,
  parameter int PWM_W   = 4
) (
  input logic clk,
  input logic rst,
  led_bank_arbiter_if.slave bus
);
  localparam int OW = $clog2(NREQ);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t              state_q;
  logic [NREQ-1:0]     gnt_q;
  logic [OW-1:0]       owner_q;
  logic [OW-1:0]       last_q;
  logic [7:0]          leds_q;
  logic [7:0]          patLatch_q;
  logic                busy_q;
  logic                slotDone_q;
  logic [DWELL_W-1:0]  dwellCnt_q;

  logic                anyReq;
  logic                slotEnd;
  logic                lit;
  logic [7:0]          litMask;
  logic                found_d;
  logic [OW-1:0]       win_d;
  logic [7:0]          winPat_d;

  assign anyReq  = |bus.req;
  assign litMask = {8{lit}};

  // A slot ends on timeout or when the owner lets go of its request;
  // both on the same edge are still one slot end.
  assign slotEnd = (state_q == HOLD) &&
                   ((dwellCnt_q == '0) || !bus.req[owner_q]);

  // Round-robin search starting just after the last owner, so the last
  // owner is considered only after every other requester.
  always_comb begin
    int idx;
    logic [OW-1:0] cand;
    found_d  = 1'b0;
    win_d    = '0;
    winPat_d = '0;
    idx      = 0;
    cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      cand = OW'(idx);
      if (!found_d && bus.req[cand]) begin
        found_d  = 1'b1;
        win_d    = cand;
        winPat_d = bus.pat[{cand, 3'b000} +: 8];
      end
    end
  end

`ifdef LED_BANK_PWM_EN
  logic [PWM_W-1:0] pwmCnt_q;

  // Free-running brightness counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwmCnt_q <= '0;
    end else begin
      pwmCnt_q <= pwmCnt_q + 1'b1;
    end
  end

  assign lit = (pwmCnt_q < bus.duty);
`else
  logic unusedDuty;
  assign unusedDuty = ^bus.duty;
  assign lit        = 1'b1;
`endif

  // Slot FSM: arbitration, dwell counting and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      last_q     <= OW'(NREQ - 1);
      leds_q     <= '0;
      patLatch_q <= '0;
      busy_q     <= 1'b0;
      slotDone_q <= 1'b0;
      dwellCnt_q <= '0;
    end else begin
      slotDone_q <= slotEnd;
      if ((state_q == IDLE) || slotEnd) begin
        if (found_d) begin
          state_q    <= HOLD;
          gnt_q      <= NREQ'(1) << win_d;
          owner_q    <= win_d;
          last_q     <= win_d;
          patLatch_q <= winPat_d;
          leds_q     <= winPat_d & litMask;
          dwellCnt_q <= DWELL_W'(DWELL - 1);
          busy_q     <= 1'b1;
        end else begin
          state_q <= IDLE;
          gnt_q   <= '0;
          leds_q  <= '0;
          busy_q  <= 1'b0;
        end
      end else begin
        dwellCnt_q <= dwellCnt_q - 1'b1;
        leds_q     <= patLatch_q & litMask;
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.owner     = owner_q;
  assign bus.leds      = leds_q;
  assign bus.busy      = busy_q;
  assign bus.slot_done = slotDone_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// tb_led_bank_arbiter
// Drives two arbiters (DWELL=4 and DWELL=1) from the same requesters and
// checks them against a slot-level reference model plus directed scenarios.
// Honors LED_BANK_PWM_EN the same way as the design.
module tb_led_bank_arbiter;
  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] pat;
  logic [3:0]  duty;

  int checks = 0;
  int errors = 0;

  led_bank_arbiter_if #(.NREQ(4), .PWM_W(4)) ifA ();
  led_bank_arbiter_if #(.NREQ(4), .PWM_W(4)) ifB ();

  assign ifA.req  = req;
  assign ifA.pat  = pat;
  assign ifA.duty = duty;
  assign ifB.req  = req;
  assign ifB.pat  = pat;
  assign ifB.duty = duty;

  led_bank_arbiter #(.NREQ(4), .DWELL_W(16), .DWELL(4), .PWM_W(4)) dutA (
    .clk(clk), .rst(rst), .bus(ifA)
  );
  led_bank_arbiter #(.NREQ(4), .DWELL_W(16), .DWELL(1), .PWM_W(4)) dutB (
    .clk(clk), .rst(rst), .bus(ifB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] oGnt[2];
  logic [1:0] oOwner[2];
  logic [7:0] oLeds[2];
  logic       oBusy[2];
  logic       oDone[2];
  assign oGnt[0] = ifA.gnt;       assign oGnt[1] = ifB.gnt;
  assign oOwner[0] = ifA.owner;   assign oOwner[1] = ifB.owner;
  assign oLeds[0] = ifA.leds;     assign oLeds[1] = ifB.leds;
  assign oBusy[0] = ifA.busy;     assign oBusy[1] = ifB.busy;
  assign oDone[0] = ifA.slot_done; assign oDone[1] = ifB.slot_done;

  // Reference model: per instance, a slot either is held (with cycles left)
  // or not; each edge either continues the slot or ends it and re-arbitrates.
  int       mSlotLen[2];
  bit       mHold[2];
  int       mOwner[2];
  int       mLast[2];
  int       mLeft[2];
  logic [7:0] mPat[2];
  logic [3:0] mGnt[2];
  logic [7:0] mLeds[2];
  bit       mBusy[2];
  bit       mDone[2];
  int       mPwm;

  initial begin
    mSlotLen[0] = 4;
    mSlotLen[1] = 1;
  end

  // Reference model advanced on every rising edge from the driven inputs.
  always @(posedge clk) begin
    bit litNow;
    bit ending;
    int win;
`ifdef LED_BANK_PWM_EN
    litNow = (mPwm < int'(duty));
`else
    litNow = 1'b1;
`endif
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mHold[d] = 0; mOwner[d] = 0; mLast[d] = 3; mLeft[d] = 0;
        mPat[d] = 8'h00; mGnt[d] = 4'h0; mLeds[d] = 8'h00;
        mBusy[d] = 0; mDone[d] = 0;
      end else begin
        ending = mHold[d] && ((mLeft[d] == 1) || !req[mOwner[d]]);
        mDone[d] = ending;
        if (!mHold[d] || ending) begin
          win = -1;
          for (int k = 1; k <= 4; k++) begin
            if (win < 0 && req[(mLast[d] + k) % 4]) win = (mLast[d] + k) % 4;
          end
          if (win >= 0) begin
            mHold[d] = 1; mOwner[d] = win; mLast[d] = win;
            mLeft[d] = mSlotLen[d];
            mPat[d] = pat[8*win +: 8];
            mGnt[d] = 4'(1 << win);
            mLeds[d] = litNow ? mPat[d] : 8'h00;
            mBusy[d] = 1;
          end else begin
            mHold[d] = 0; mGnt[d] = 4'h0; mLeds[d] = 8'h00; mBusy[d] = 0;
          end
        end else begin
          mLeft[d] = mLeft[d] - 1;
          mLeds[d] = litNow ? mPat[d] : 8'h00;
        end
      end
    end
    if (rst) mPwm = 0;
    else mPwm = (mPwm + 1) % 16;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'h0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({oGnt[d], oOwner[d], oLeds[d], oBusy[d], oDone[d]} !== 16'h0) begin
        errors++;
        $display("[TB] FAIL reset_outputs dut%0d: got gnt=%b owner=%0d leds=%h busy=%b done=%b required all 0",
                 d, oGnt[d], oOwner[d], oLeds[d], oBusy[d], oDone[d]);
      end
    end
  endtask

  task automatic test_single_request();
    do_reset();
    pat = 32'h0000_A500;
    req = 4'b0010;
    step();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (ifA.gnt !== 4'b0010 || ifA.busy !== 1'b1 || ifA.owner !== 2'd1) begin
        errors++;
        $display("[TB] FAIL single_grant cycle%0d: got gnt=%b busy=%b owner=%0d required 0010/1/1", c, ifA.gnt, ifA.busy, ifA.owner);
      end
      checks++;
      if (ifA.slot_done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL single_done_early cycle%0d: got %b required 0", c, ifA.slot_done);
      end
      checks++;
      if (ifA.leds !== mLeds[0]) begin
        errors++;
        $display("[TB] FAIL single_leds_model cycle%0d: got %h required %h", c, ifA.leds, mLeds[0]);
      end
`ifndef LED_BANK_PWM_EN
      checks++;
      if (ifA.leds !== 8'hA5) begin
        errors++;
        $display("[TB] FAIL single_leds cycle%0d: got %h required a5", c, ifA.leds);
      end
`endif
      step();
    end
    checks++;
    if (ifA.slot_done !== 1'b1 || ifA.gnt !== 4'b0010 || ifA.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_regrant: got done=%b gnt=%b busy=%b required 1/0010/1", ifA.slot_done, ifA.gnt, ifA.busy);
    end
    req = 4'b0000;
    step();
    checks++;
    if (ifA.gnt !== 4'b0000 || ifA.busy !== 1'b0 || ifA.leds !== 8'h00 ||
        ifA.owner !== 2'd1 || ifA.slot_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_release: got gnt=%b busy=%b leds=%h owner=%0d done=%b required 0000/0/00/1/1",
               ifA.gnt, ifA.busy, ifA.leds, ifA.owner, ifA.slot_done);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] expA;
    logic [3:0] expB;
    do_reset();
    pat = 32'h8844_2211;
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      step();
      expA = 4'(1 << ((c / 4) % 4));
      expB = 4'(1 << (c % 4));
      checks++;
      if (ifA.gnt !== expA || ifA.slot_done !== (c > 0 && c % 4 == 0) || ifA.busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rotation_dwell4 cycle%0d: got gnt=%b done=%b busy=%b required %b/%b/1",
                 c, ifA.gnt, ifA.slot_done, ifA.busy, expA, (c > 0 && c % 4 == 0));
      end
      checks++;
      if (ifB.gnt !== expB || ifB.slot_done !== (c > 0)) begin
        errors++;
        $display("[TB] FAIL rotation_dwell1 cycle%0d: got gnt=%b done=%b required %b/%b",
                 c, ifB.gnt, ifB.slot_done, expB, (c > 0));
      end
    end
  endtask

  task automatic test_abort();
    do_reset();
    pat = 32'h0055_0000;
    req = 4'b0100;
    step();
    checks++;
    if (ifA.gnt !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL abort_setup: got gnt=%b required 0100", ifA.gnt);
    end
    req = 4'b0001;
    step();
    checks++;
    if (ifA.gnt !== 4'b0001 || ifA.slot_done !== 1'b1 || ifA.owner !== 2'd0) begin
      errors++;
      $display("[TB] FAIL abort_switch: got gnt=%b done=%b owner=%0d required 0001/1/0", ifA.gnt, ifA.slot_done, ifA.owner);
    end
    step();
    checks++;
    if (ifA.slot_done !== 1'b0 || ifA.gnt !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL abort_single_pulse: got done=%b gnt=%b required 0/0001", ifA.slot_done, ifA.gnt);
    end
  endtask

  task automatic test_pattern_latch();
    do_reset();
    pat = 32'h0000_003C;
    req = 4'b0001;
    step();
    pat = 32'h0000_00C3;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (ifA.leds !== mLeds[0]) begin
        errors++;
        $display("[TB] FAIL latch_model cycle%0d: got %h required %h", c, ifA.leds, mLeds[0]);
      end
`ifndef LED_BANK_PWM_EN
      checks++;
      if (ifA.leds !== 8'h3C) begin
        errors++;
        $display("[TB] FAIL latch_hold cycle%0d: got %h required 3c", c, ifA.leds);
      end
`endif
    end
    step();
`ifndef LED_BANK_PWM_EN
    checks++;
    if (ifA.leds !== 8'hC3 || ifA.slot_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latch_regrant: got leds=%h done=%b required c3/1", ifA.leds, ifA.slot_done);
    end
`else
    checks++;
    if (ifA.leds !== mLeds[0] || ifA.slot_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latch_regrant: got leds=%h done=%b required %h/1", ifA.leds, ifA.slot_done, mLeds[0]);
    end
`endif
  endtask

  task automatic test_reset_mid_slot();
    do_reset();
    pat = 32'hFFFF_FFFF;
    req = 4'b0100;
    step();
    step();
    rst = 1'b1;
    step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({oGnt[d], oOwner[d], oLeds[d], oBusy[d], oDone[d]} !== 16'h0) begin
        errors++;
        $display("[TB] FAIL reset_mid dut%0d: got gnt=%b owner=%0d leds=%h busy=%b done=%b required all 0",
                 d, oGnt[d], oOwner[d], oLeds[d], oBusy[d], oDone[d]);
      end
    end
    rst = 1'b0;
    req = 4'b1111;
    step();
    checks++;
    if (ifA.gnt !== 4'b0001 || ifB.gnt !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL reset_mid_first_grant: got %b/%b required 0001/0001", ifA.gnt, ifB.gnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 39) == 0) rst = 1'b1;
      else rst = 1'b0;
      if ($urandom_range(0, 9) < 3) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) pat = $urandom;
      if ($urandom_range(0, 19) == 0) duty = 4'($urandom_range(0, 15));
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (oGnt[d] !== mGnt[d] || oOwner[d] !== 2'(mOwner[d]) || oLeds[d] !== mLeds[d] ||
            oBusy[d] !== mBusy[d] || oDone[d] !== mDone[d]) begin
          errors++;
          $display("[TB] FAIL random dut%0d cycle%0d: got gnt=%b owner=%0d leds=%h busy=%b done=%b required %b/%0d/%h/%b/%b",
                   d, c, oGnt[d], oOwner[d], oLeds[d], oBusy[d], oDone[d],
                   mGnt[d], mOwner[d], mLeds[d], mBusy[d], mDone[d]);
        end
      end
    end
    rst = 1'b0;
  endtask

`ifdef LED_BANK_PWM_EN
  task automatic test_pwm();
    int onCount;
    do_reset();
    pat  = 32'h0000_00FF;
    duty = 4'd4;
    req  = 4'b0001;
    step();
    onCount = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (ifA.leds === 8'hFF) onCount++;
      checks++;
      if (ifA.leds !== 8'hFF && ifA.leds !== 8'h00) begin
        errors++;
        $display("[TB] FAIL pwm_levels cycle%0d: got %h required ff or 00", c, ifA.leds);
      end
    end
    checks++;
    if (onCount != 4) begin
      errors++;
      $display("[TB] FAIL pwm_duty4: got %0d on-cycles required 4", onCount);
    end
    duty = 4'd0;
    for (int c = 0; c < 16; c++) begin
      step();
      checks++;
      if (ifA.leds !== 8'h00) begin
        errors++;
        $display("[TB] FAIL pwm_duty0 cycle%0d: got %h required 00", c, ifA.leds);
      end
    end
    duty = 4'hF;
  endtask
`endif

  initial begin
    rst  = 1'b1;
    req  = 4'h0;
    pat  = 32'h0;
    duty = 4'hF;
    @(negedge clk);
    test_reset();
    test_single_request();
    test_rotation();
    test_abort();
    test_pattern_latch();
    test_reset_mid_slot();
`ifdef LED_BANK_PWM_EN
    test_pwm();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
